barrel_shift_arbiter: RTL and testbench

Shares one 8-bit `Barrel_Shifter` among four requesters. Each requester presents an operand, a shift amount and a direction under a valid/ready handshake. A round-robin arbiter grants one requester per accept. The block registers the winner's operands and returns the rotated result with the winner's ID on a single response channel. It sits between the client blocks and the shifter datapath, so no client drives the shifter directly.

---
 rtl/bsa_pkg.sv | 19 +
 rtl/Barrel_Shifter.sv | 24 ++
 rtl/rr_arbiter4.sv | 24 ++
 rtl/barrel_shift_arbiter.sv | 101 ++++++++++
 tb/tb_barrel_shift_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bsa_pkg.sv
// Shared constants, types and state encoding for barrel_shift_arbiter.
package bsa_pkg;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int NW   = 3;
  localparam int IDW  = 2;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic {IDLE, FULL} state_e;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [NW-1:0]  n;
    logic           lr;
    logic [IDW-1:0] id;
  } req_t;
endpackage

// File: rtl/Barrel_Shifter.sv
// 8-bit rotator: Lr = 1 rotates left by n, Lr = 0 rotates right by n.
module Barrel_Shifter
  import bsa_pkg::*;
(
  output logic [W-1:0]  Out,
  input  logic [W-1:0]  In,
  input  logic [NW-1:0] n,
  input  logic          Lr
);
  logic [2*W-1:0] dbl;

  // Shifting a doubled copy makes the wrapped bits fall into the kept half.
  always_comb begin
    dbl = '0;
    Out = '0;
    if (Lr == DIR_LEFT) begin
      dbl = {In, In} << n;
      Out = dbl[2*W-1:W];
    end else begin
      dbl = {In, In} >> n;
      Out = dbl[W-1:0];
    end
  end
endmodule

// File: rtl/rr_arbiter4.sv
// Combinational round-robin select: first valid index at or after ptr.
module rr_arbiter4
  import bsa_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic            found
);
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/barrel_shift_arbiter.sv
// Four requesters share one Barrel_Shifter through a round-robin arbiter.
// Optional per-requester saturating accept counters under BSA_STATS_EN.
module barrel_shift_arbiter
  import bsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ*NW-1:0] req_n,
  input  logic [NREQ-1:0]   req_lr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id
`ifdef BSA_STATS_EN
  ,
  output logic [NREQ*8-1:0] grant_cnt
`endif
);
  state_e state, nstate;
  logic [IDW-1:0] ptr;
  logic [NREQ-1:0] grant;
  logic found, go;
  logic [IDW-1:0] win;
  req_t hold;

  logic [NREQ-1:0][W-1:0]  data_a;
  logic [NREQ-1:0][NW-1:0] n_a;
  assign data_a = req_data;
  assign n_a    = req_n;

  rr_arbiter4 u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .found     (found)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) win = IDW'(i);
  end

  // A slot opens when empty or when the held result leaves this cycle.
  assign go = found && !rst && (state == IDLE || resp_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (go) nstate = FULL;
      FULL:    if (go) nstate = FULL;
               else if (resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = go ? grant : '0;
    resp_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      ptr  <= '0;
    end else if (go) begin
      hold <= '{data: data_a[win], n: n_a[win], lr: req_lr[win], id: win};
      ptr  <= win + IDW'(1);
    end
  end

  Barrel_Shifter u_bs (
    .Out (resp_data),
    .In  (hold.data),
    .n   (hold.n),
    .Lr  (hold.lr)
  );

  assign resp_id = hold.id;

`ifdef BSA_STATS_EN
  logic [NREQ-1:0][7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (go && cnt[win] != 8'hFF)
      cnt[win] <= cnt[win] + 8'd1;
  end

  assign grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: directed scenarios plus random traffic vs a cycle model.
module tb_barrel_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [11:0] req_n;
  logic [3:0]  req_lr;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
`ifdef BSA_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: occupancy, priority pointer, held result, counters.
  bit m_full;
  int m_ptr, m_data, m_id;
  int m_cnt[4];

  always #5 clk = ~clk;

  barrel_shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_n      (req_n),
    .req_lr     (req_lr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
`ifdef BSA_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rot(input int d, input int n, input bit lr);
    if (n == 0) return d;
    if (lr) return ((d << n) | (d >> (8 - n))) & 255;
    return ((d >> n) | (d << (8 - n))) & 255;
  endfunction

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] n, input bit lr);
    req_data[i*8 +: 8] = d;
    req_n[i*3 +: 3]    = n;
    req_lr[i]          = lr;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int w, idx, e_rdy;
    bit go;
`ifdef BSA_STATS_EN
    logic [31:0] e_cnt;
`endif
    #1;
    w = -1;
    if (!rst)
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    go = (w >= 0) && (!m_full || resp_ready);
    e_rdy = go ? (1 << w) : 0;
    chk("req_ready", {28'd0, req_ready}, e_rdy);
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_full});
    if (m_full) begin
      chk("resp_data", {24'd0, resp_data}, m_data);
      chk("resp_id", {30'd0, resp_id}, m_id);
    end
`ifdef BSA_STATS_EN
    e_cnt = {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
    chk("grant_cnt", grant_cnt, e_cnt);
`endif
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_ptr = 0; m_data = 0; m_id = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (go) begin
      m_data = rot(int'(req_data[w*8 +: 8]), int'(req_n[w*3 +: 3]), req_lr[w]);
      m_id   = w;
      m_ptr  = (w + 1) % 4;
      m_full = 1;
      if (m_cnt[w] < 255) m_cnt[w]++;
    end else if (m_full && resp_ready) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_data = 0; req_n = 0; req_lr = 0; resp_ready = 1;
    @(negedge clk);
    step();
    chk("rst_valid", {31'd0, resp_valid}, 0);
    chk("rst_data", {24'd0, resp_data}, 0);
    chk("rst_id", {30'd0, resp_id}, 0);
    rst = 0;

    // Single request, rotate left.
    set_req(0, 8'hAA, 3'd1, 1'b1); req_valid = 4'b0001;
    step();
    req_valid = 0;
    chk("t1_data", {24'd0, resp_data}, 32'h55);
    chk("t1_id", {30'd0, resp_id}, 0);
    step();

    // Single request, rotate right.
    set_req(2, 8'b1010_1010, 3'd2, 1'b0); req_valid = 4'b0100;
    step();
    req_valid = 0;
    chk("t2_data", {24'd0, resp_data}, 32'hAA);
    chk("t2_id", {30'd0, resp_id}, 2);
    step();

    // Round robin from a fresh pointer.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h11 * (i + 1)), 3'(i), 1'b1);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_id", {30'd0, resp_id}, i % 4);
      chk("rr_valid", {31'd0, resp_valid}, 1);
    end

    // Backpressure holding a result from requester 1.
    set_req(1, 8'h0F, 3'd0, 1'b0); req_valid = 4'b0010;
    step();
    req_valid = 4'b1111; resp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", {24'd0, resp_data}, 32'h0F);
      chk("bp_id", {30'd0, resp_id}, 1);
      chk("bp_ready", {28'd0, req_ready}, 0);
    end
    resp_ready = 1;
    step();
    chk("bp_next_id", {30'd0, resp_id}, 2);

    // Reset while a result is held.
    rst = 1;
    step();
    chk("mid_rst_valid", {31'd0, resp_valid}, 0);
    rst = 0;
    step();
    chk("mid_rst_ptr", {30'd0, resp_id}, 0);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      req_valid  = 4'($urandom);
      req_data   = $urandom;
      req_n      = 12'($urandom);
      req_lr     = 4'($urandom);
      resp_ready = ($urandom % 4) != 0;
      rst        = ($urandom % 64) == 0;
      step();
    end
    rst = 0;

`ifdef BSA_STATS_EN
    rst = 1; step(); rst = 0;
    resp_ready = 1; req_valid = 4'b1000;
    for (int c = 0; c < 300; c++) step();
    req_valid = 0;
    chk("stats_r3", {24'd0, grant_cnt[31:24]}, 255);
    chk("stats_rest", {8'd0, grant_cnt[23:0]}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
